// File: rtl/core_data_port.sv
// Data-side memory port: routes pipeline loads/stores to local memory or the shared bus.
// Define FEATURE_WRITE_BUFFER_EN for posted shared writes through a write buffer and registered bus outputs.
module core_data_port #(
    parameter int LOCAL_MEMORY_SIZE = 2048,
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 16,
    parameter int LOCAL_SEL_BITS    = 2,
    parameter int WB_DEPTH          = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    // pipeline side
    input  logic [ADDR_WIDTH-1:0]              daddr,
    input  logic                               dwrite_en,
    input  logic                               dread_en,
    input  logic [DATA_WIDTH-1:0]              ddata_out,
    output logic [DATA_WIDTH-1:0]              ddata_in,
    output logic                               stall,
    // local memory
    output logic [$clog2(LOCAL_MEMORY_SIZE)-1:0] lmem_addr,
    output logic                               lmem_we,
    output logic [DATA_WIDTH-1:0]              lmem_wdata,
    input  logic [DATA_WIDTH-1:0]              lmem_q,
    // shared bus
    output logic [ADDR_WIDTH-1:0]              shared_addr,
    output logic                               shared_wren,
    output logic                               shared_rden,
    output logic [DATA_WIDTH-1:0]              shared_write_val,
    output logic                               shared_request,
    input  logic                               shared_ready,
    input  logic [DATA_WIDTH-1:0]              shared_read_val,
    // status
    output logic [$clog2(WB_DEPTH):0]          wb_count
);

    localparam int LA = $clog2(LOCAL_MEMORY_SIZE);

    logic sel_local;
    logic is_rd;
    logic local_rd;
    logic shared_rd;
    logic shared_wr;
    logic rd_done;

    // A simultaneous read and write is a write.
    assign sel_local = (daddr[ADDR_WIDTH-1 -: LOCAL_SEL_BITS] == '0);
    assign is_rd     = dread_en & ~dwrite_en;
    assign local_rd  = sel_local & is_rd;
    assign shared_rd = ~sel_local & is_rd;
    assign shared_wr = ~sel_local & dwrite_en;

    assign lmem_addr  = daddr[LA-1:0];
    assign lmem_we    = sel_local & dwrite_en;
    assign lmem_wdata = ddata_out;

    // ------------------------------------------------------------------
    // Read return path: one cycle after completion for both sources.
    // ------------------------------------------------------------------
    logic                  rd_valid_q;
    logic                  src_local_q;
    logic [DATA_WIDTH-1:0] rd_capture_q;
    logic [DATA_WIDTH-1:0] ddata_hold_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q   <= 1'b0;
            src_local_q  <= 1'b1;
            rd_capture_q <= '0;
            ddata_hold_q <= '0;
        end else begin
            ddata_hold_q <= ddata_in;
            if (local_rd) begin
                rd_valid_q  <= 1'b1;
                src_local_q <= 1'b1;
            end else if (rd_done) begin
                rd_valid_q   <= 1'b1;
                src_local_q  <= 1'b0;
                rd_capture_q <= shared_read_val;
            end else begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    // lmem_q moves with later accesses, so the last returned word is held separately.
    assign ddata_in = !rd_valid_q ? ddata_hold_q :
                      (src_local_q ? lmem_q : rd_capture_q);

`ifdef FEATURE_WRITE_BUFFER_EN

    localparam int PW = $clog2(WB_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] wb_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_inc;
    logic [PW:0]           count;
    logic                  full;
    logic                  push;
    logic                  pop;

    logic                  req_nxt;
    logic                  wren_nxt;
    logic                  rden_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wval_nxt;

    // count never exceeds WB_DEPTH (a power of two), so its MSB alone means full.
    assign full       = count[PW];
    assign push       = shared_wr & ~full;
    assign pop        = (state == DRAIN) & shared_ready;
    assign rd_done    = (state == READ) & shared_ready;
    assign rd_ptr_inc = rd_ptr + PW'(1);
    assign wb_count   = count;

    assign stall = (shared_wr & full) | (shared_rd & ~rd_done);

    // NOTE: buffer storage has no reset; the pointers and count define validity,
    // so after reset stale entries are never issued.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr] <= daddr;
            wb_data[wr_ptr] <= ddata_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        wren_nxt  = 1'b0;
        rden_nxt  = 1'b0;
        addr_nxt  = '0;
        wval_nxt  = '0;
        case (state)
            IDLE: begin
                // Pending writes go out before any pipeline read.
                if (count != '0) begin
                    state_nxt = DRAIN;
                    req_nxt   = 1'b1;
                    wren_nxt  = 1'b1;
                    addr_nxt  = wb_addr[rd_ptr];
                    wval_nxt  = wb_data[rd_ptr];
                end else if (shared_rd) begin
                    state_nxt = READ;
                    req_nxt   = 1'b1;
                    rden_nxt  = 1'b1;
                    addr_nxt  = daddr;
                end
            end
            DRAIN: begin
                if (!shared_ready) begin
                    req_nxt  = 1'b1;
                    wren_nxt = 1'b1;
                    addr_nxt = shared_addr;
                    wval_nxt = shared_write_val;
                end else if (count != (PW+1)'(1)) begin
                    req_nxt  = 1'b1;
                    wren_nxt = 1'b1;
                    addr_nxt = wb_addr[rd_ptr_inc];
                    wval_nxt = wb_data[rd_ptr_inc];
                end else begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (!shared_ready) begin
                    req_nxt  = 1'b1;
                    rden_nxt = 1'b1;
                    addr_nxt = shared_addr;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            shared_request   <= 1'b0;
            shared_wren      <= 1'b0;
            shared_rden      <= 1'b0;
            shared_addr      <= '0;
            shared_write_val <= '0;
        end else begin
            state            <= state_nxt;
            shared_request   <= req_nxt;
            shared_wren      <= wren_nxt;
            shared_rden      <= rden_nxt;
            shared_addr      <= addr_nxt;
            shared_write_val <= wval_nxt;
        end
    end

`else

    assign shared_request   = shared_wr | shared_rd;
    assign shared_wren      = shared_wr;
    assign shared_rden      = shared_rd;
    assign shared_addr      = daddr;
    assign shared_write_val = ddata_out;
    assign stall            = shared_request & ~shared_ready;
    assign rd_done          = shared_rd & shared_ready;
    assign wb_count         = '0;

`endif

endmodule
